// File: rtl/wb_stage.sv
// Registered write-back stage: holds one instruction from MEM, aligns and
// extends sub-word loads, selects the final result and drives the
// register-file write port, the forwarding bus and a retire counter.
module wb_stage #(
  parameter int          REG_AW   = 5,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] LINK_OFF = 32'd8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [1:0]        in_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [31:0]       in_alu,
  input  logic [31:0]       in_rdata,
  input  logic [31:0]       in_cp0,
  input  logic [31:0]       in_pc,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_sign,
  input  logic              hold,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [31:0]       fwd_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [31:0]       debug_pc
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_CP0  = 2'd2;
  localparam logic [1:0] SEL_LINK = 2'd3;

  // Stage register contents
  logic              v_q, v_d;
  logic              regwrite_q;
  logic [1:0]        sel_q;
  logic [REG_AW-1:0] rd_q;
  logic [31:0]       alu_q;
  logic [31:0]       rdata_q;
  logic [31:0]       cp0_q;
  logic [31:0]       pc_q;
  logic [1:0]        ld_size_q;
  logic              ld_sign_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              leave;
  logic              writes_gpr;
  logic [31:0]       result;

  // Pick the addressed byte/half out of the memory word and extend it.
  // Odd half-word offsets cannot reach here, so only off[1] selects the half.
  function automatic logic [31:0] load_extract(
    input logic [31:0] rdata,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        sign
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    r = {{24{sign & b[7]}}, b};
      2'd1:    r = {{16{sign & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Handshake, result selection and next-state computation
  always_comb begin
    in_ready   = !flush && (!v_q || !hold);
    accept     = in_valid && in_ready;
    leave      = v_q && !hold && !flush;
    writes_gpr = regwrite_q && (rd_q != '0);

    case (sel_q)
      SEL_ALU:  result = alu_q;
      SEL_MEM:  result = load_extract(rdata_q, alu_q[1:0], ld_size_q, ld_sign_q);
      SEL_CP0:  result = cp0_q;
      SEL_LINK: result = pc_q + LINK_OFF;
      default:  result = alu_q;
    endcase

    // A flush kills the entry even when it is held; acceptance wins over leave.
    if (accept)              v_d = 1'b1;
    else if (leave || flush) v_d = 1'b0;
    else                     v_d = v_q;

    cnt_d = leave ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Write-port, forwarding and debug outputs from the held entry
  always_comb begin
    rf_we      = leave && writes_gpr;
    rf_waddr   = v_q ? rd_q : '0;
    rf_wdata   = v_q ? result : '0;
    fwd_valid  = v_q && writes_gpr;
    fwd_addr   = rd_q;
    fwd_data   = result;
    retire_cnt = cnt_q;
    debug_pc   = v_q ? pc_q : '0;
  end

  // Stage register: capture on accept, track occupancy and retirements
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q        <= 1'b0;
      regwrite_q <= 1'b0;
      sel_q      <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      cp0_q      <= '0;
      pc_q       <= '0;
      ld_size_q  <= '0;
      ld_sign_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      if (accept) begin
        regwrite_q <= in_regwrite;
        sel_q      <= in_sel;
        rd_q       <= in_rd;
        alu_q      <= in_alu;
        rdata_q    <= in_rdata;
        cp0_q      <= in_cp0;
        pc_q       <= in_pc;
        ld_size_q  <= in_ld_size;
        ld_sign_q  <= in_ld_sign;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of single-instruction vectors streamed
// back-to-back, plus hand-written hold, flush, wrap and reset sequences.
// Expected register-file writes go through a scoreboard queue.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [1:0]  in_sel;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_rdata;
  logic [31:0] in_cp0;
  logic [31:0] in_pc;
  logic [1:0]  in_ld_size;
  logic        in_ld_sign;
  logic        hold;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [3:0]  retire_cnt;
  logic [31:0] debug_pc;

  wb_stage #(.REG_AW(5), .CNT_W(4), .LINK_OFF(32'd8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_sel(in_sel), .in_rd(in_rd), .in_alu(in_alu), .in_rdata(in_rdata),
    .in_cp0(in_cp0), .in_pc(in_pc), .in_ld_size(in_ld_size),
    .in_ld_sign(in_ld_sign), .hold(hold), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt), .debug_pc(debug_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        sign;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] cp0;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t tbl [16];
  wr_t  sb_q [$];
  int   checks;
  int   failures;
  logic mon_en;

  function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] size,
                              input logic sign, input logic rw, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] rdata,
                              input logic [31:0] cp0, input logic [31:0] pc,
                              input logic [31:0] exp);
    vec_t t;
    t.sel = sel; t.size = size; t.sign = sign; t.rw = rw; t.rd = rd;
    t.alu = alu; t.rdata = rdata; t.cp0 = cp0; t.pc = pc; t.exp = exp;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    in_valid = 1'b1; in_sel = t.sel; in_ld_size = t.size; in_ld_sign = t.sign;
    in_regwrite = t.rw; in_rd = t.rd; in_alu = t.alu; in_rdata = t.rdata;
    in_cp0 = t.cp0; in_pc = t.pc;
  endtask

  // Drive one instruction for one edge; push its expected write if any.
  task automatic send(input vec_t t, input logic push);
    wr_t w;
    apply(t);
    if (push && t.rw && t.rd != 5'd0) begin
      w.addr = t.rd;
      w.data = t.exp;
      sb_q.push_back(w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every write-port pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && rf_we) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_write: unexpected write r%0d=0x%08h, expected none", rf_waddr, rf_wdata);
      end else begin
        wr_t w;
        w = sb_q.pop_front();
        if (rf_waddr !== w.addr || rf_wdata !== w.data) begin
          failures++;
          $display("FAIL sb_write: got r%0d=0x%08h expected r%0d=0x%08h",
                   rf_waddr, rf_wdata, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    vec_t t;
    checks = 0; failures = 0; mon_en = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_sel = 2'd0; in_rd = 5'd0;
    in_alu = 32'd0; in_rdata = 32'd0; in_cp0 = 32'd0; in_pc = 32'd0;
    in_ld_size = 2'd0; in_ld_sign = 1'b0; hold = 1'b0; flush = 1'b0;

    //            sel   size  sgn  rw   rd     alu            rdata          cp0            pc             expected
    tbl[0]  = mk(2'd1, 2'd0, 1'b1, 1'b1, 5'd3,  32'h00001003, 32'h80123456, 32'h0,         32'h00001000, 32'hFFFFFF80);
    tbl[1]  = mk(2'd1, 2'd0, 1'b0, 1'b1, 5'd3,  32'h00001003, 32'h80123456, 32'h0,         32'h00001004, 32'h00000080);
    tbl[2]  = mk(2'd1, 2'd1, 1'b1, 1'b1, 5'd4,  32'h00000002, 32'h80011234, 32'h0,         32'h00001008, 32'hFFFF8001);
    tbl[3]  = mk(2'd1, 2'd1, 1'b1, 1'b1, 5'd4,  32'h00000000, 32'h80011234, 32'h0,         32'h0000100C, 32'h00001234);
    tbl[4]  = mk(2'd1, 2'd0, 1'b1, 1'b1, 5'd6,  32'h00000001, 32'h80123456, 32'h0,         32'h00001010, 32'h00000034);
    tbl[5]  = mk(2'd1, 2'd0, 1'b0, 1'b1, 5'd6,  32'h00000000, 32'h000000F0, 32'h0,         32'h00001014, 32'h000000F0);
    tbl[6]  = mk(2'd1, 2'd0, 1'b1, 1'b1, 5'd8,  32'h00000002, 32'h00A50000, 32'h0,         32'h00001018, 32'hFFFFFFA5);
    tbl[7]  = mk(2'd1, 2'd2, 1'b1, 1'b1, 5'd9,  32'h00000000, 32'hCAFEF00D, 32'h0,         32'h0000101C, 32'hCAFEF00D);
    tbl[8]  = mk(2'd1, 2'd3, 1'b1, 1'b1, 5'd9,  32'h00000003, 32'h12345678, 32'h0,         32'h00001020, 32'h12345678);
    tbl[9]  = mk(2'd1, 2'd1, 1'b0, 1'b1, 5'd10, 32'h00000003, 32'hBEEF0000, 32'h0,         32'h00001024, 32'h0000BEEF);
    tbl[10] = mk(2'd0, 2'd0, 1'b1, 1'b1, 5'd11, 32'h11223344, 32'hFFFFFFFF, 32'h0,         32'h00001028, 32'h11223344);
    tbl[11] = mk(2'd2, 2'd0, 1'b0, 1'b1, 5'd12, 32'h00000000, 32'h0,        32'hDEADBEEF, 32'h0000102C, 32'hDEADBEEF);
    tbl[12] = mk(2'd3, 2'd0, 1'b0, 1'b1, 5'd31, 32'h00000000, 32'h0,        32'h0,         32'h00400010, 32'h00400018);
    tbl[13] = mk(2'd3, 2'd0, 1'b0, 1'b1, 5'd30, 32'h00000000, 32'h0,        32'h0,         32'hFFFFFFFC, 32'h00000004);
    tbl[14] = mk(2'd0, 2'd0, 1'b0, 1'b1, 5'd0,  32'h00000077, 32'h0,        32'h0,         32'h00001038, 32'h00000077);
    tbl[15] = mk(2'd0, 2'd0, 1'b0, 1'b0, 5'd5,  32'h00000066, 32'h0,        32'h0,         32'h0000103C, 32'h00000066);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_fwd_addr", 32'(fwd_addr), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_debug_pc", debug_pc, 32'd0);
    chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
    mon_en = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table vectors, streamed back-to-back (one accept per edge)
    for (int i = 0; i < 16; i++) begin
      send(tbl[i], 1'b1);
      chk($sformatf("vec%0d_fwd_valid", i), 32'(fwd_valid),
          32'(tbl[i].rw && tbl[i].rd != 5'd0));
      if (tbl[i].rw && tbl[i].rd != 5'd0) begin
        chk($sformatf("vec%0d_fwd_addr", i), 32'(fwd_addr), 32'(tbl[i].rd));
        chk($sformatf("vec%0d_fwd_data", i), fwd_data, tbl[i].exp);
      end
      chk($sformatf("vec%0d_debug_pc", i), debug_pc, tbl[i].pc);
      chk($sformatf("vec%0d_retire_cnt", i), 32'(retire_cnt), 32'(i));
    end
    @(posedge clk); #1;
    chk("wrap_retire_cnt", 32'(retire_cnt), 32'd0);
    chk("idle_debug_pc", debug_pc, 32'd0);
    chk("idle_rf_wdata", rf_wdata, 32'd0);

    // Hold for 3 cycles, then a single write when released (17th retire -> 1)
    hold = 1'b1;
    t = mk(2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 32'h00000055, 32'h0, 32'h0, 32'h00002000, 32'h00000055);
    send(t, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_rf_we", c), 32'(rf_we), 32'd0);
      chk($sformatf("hold%0d_fwd_valid", c), 32'(fwd_valid), 32'd1);
      chk($sformatf("hold%0d_fwd_data", c), fwd_data, 32'h00000055);
      chk($sformatf("hold%0d_retire_cnt", c), 32'(retire_cnt), 32'd0);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    #1;
    chk("release_rf_we", 32'(rf_we), 32'd1);
    chk("release_rf_waddr", 32'(rf_waddr), 32'd7);
    @(posedge clk); #1;
    chk("release_retire_cnt", 32'(retire_cnt), 32'd1);
    chk("release_fwd_valid", 32'(fwd_valid), 32'd0);

    // Flush during hold with a new instruction presented
    hold = 1'b1;
    t = mk(2'd0, 2'd0, 1'b0, 1'b1, 5'd9, 32'h00000099, 32'h0, 32'h0, 32'h00003000, 32'h00000099);
    send(t, 1'b0);
    t = mk(2'd0, 2'd0, 1'b0, 1'b1, 5'd10, 32'h000000AA, 32'h0, 32'h0, 32'h00003004, 32'h000000AA);
    apply(t);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_rf_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_debug_pc", debug_pc, 32'd0);
    chk("flush_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("flush_retire_cnt", 32'(retire_cnt), 32'd1);
    apply(t);
    #1;
    chk("post_flush_in_ready", 32'(in_ready), 32'd1);
    send(t, 1'b1);
    chk("post_flush_debug_pc", debug_pc, 32'h00003004);
    @(posedge clk); #1;
    chk("post_flush_retire_cnt", 32'(retire_cnt), 32'd2);

    // Reset while an entry is held: no write after release
    hold = 1'b1;
    t = mk(2'd0, 2'd0, 1'b0, 1'b1, 5'd4, 32'h00000044, 32'h0, 32'h0, 32'h00000400, 32'h00000044);
    send(t, 1'b0);
    chk("held_debug_pc", debug_pc, 32'h00000400);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_debug_pc", debug_pc, 32'd0);
    chk("mid_rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("mid_rst_retire_cnt", 32'(retire_cnt), 32'd0);
    chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
    reset = 1'b1; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_retire_cnt", 32'(retire_cnt), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered write-back stage for the 5-stage CPU; successor to the combinational write-back mux.
- Holds one instruction from MEM in a valid/ready stage register.
- Aligns and extends sub-word loads, then selects the result from ALU, memory, CP0 or the link address.
- Drives the register-file write port, a forwarding bus and a retired-instruction counter, with hold (stall) and flush support.

Parameters:
- REG_AW, 5: register address width.
- CNT_W, 32: retire counter width.
- LINK_OFF, 8: constant added to in_pc for link writes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low; state clears on rising clk while reset==0
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_regwrite  in  1  instruction writes a GPR
- in_sel  in  2  result source: 0=ALU, 1=MEM, 2=CP0, 3=LINK
- in_rd  in  REG_AW  destination register
- in_alu  in  32  ALU result; bits [1:0] are the load byte offset
- in_rdata  in  32  raw aligned memory word
- in_cp0  in  32  CP0 read data (mfc0)
- in_pc  in  32  instruction PC
- in_ld_size  in  2  0=byte, 1=half, 2=word (3 treated as word)
- in_ld_sign  in  1  1=sign-extend, 0=zero-extend
- hold  in  1  freeze the held entry (downstream/debug stall)
- flush  in  1  kill the held entry and block acceptance this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  32  write data
- fwd_valid  out  1  held entry will produce a GPR result
- fwd_addr  out  REG_AW  forwarded register
- fwd_data  out  32  forwarded value
- retire_cnt  out  CNT_W  count of retired instructions
- debug_pc  out  32  PC of the held entry

Behaviour:
Reset
- Clears v (entry valid), all stored fields and retire_cnt.
- Outputs at reset: in_ready=1, rf_we=0, fwd_valid=0, rf_waddr=0, rf_wdata=0, fwd_addr=0, fwd_data=0, debug_pc=0, retire_cnt=0.
- Reset takes priority over all inputs, including mid-hold.

Handshake
- in_ready = !flush & (!v | !hold).
- Accept = in_valid & in_ready: all in_* fields are registered; v<=1 on the next edge.
- Leave = v & !hold & !flush. If there is a leave and no accept, v<=0.
- Accept and leave in the same cycle are allowed; throughput is 1 per cycle.
- Latency: accept at edge N; write visible on rf_* during cycle N..N+1, committed at edge N+1 if not held.

Flush
- Flush has priority over hold: v<=0 on the next edge and no accept that cycle.
- rf_we=0 in the flush cycle.
- retire_cnt does not increment.

Hold
- Entry and all outputs stay stable while held.
- rf_we=0 while hold=1, so the write occurs exactly once, in the leave cycle.

Load extraction (from stored fields)
- off = alu[1:0].
- byte = rdata[8*off +: 8].
- half = rdata[16*off[1] +: 16]; off[0] is ignored (misalignment is trapped upstream).
- word = rdata.
- Extension follows ld_sign.

Result mux and write-port outputs
- result = ALU: alu; MEM: extracted load; CP0: cp0; LINK: pc+LINK_OFF (mod 2^32).
- rf_we = leave & regwrite & (rd!=0).
- rf_waddr = rd; rf_wdata = result; both are driven whenever v=1, and 0 when v=0.
- No write is ever issued to r0.

Forwarding
- fwd_valid = v & regwrite & (rd!=0), independent of hold.
- fwd_addr = rd; fwd_data = result.

Retire counter
- retire_cnt increments by 1 on every leave, including non-writing instructions.
- Wraps from 2^CNT_W-1 to 0.

Debug
- debug_pc = stored pc when v=1, else 0.

Test Plan:
- Byte load, sign: in_sel=1, size=0, sign=1, alu=0x1003, rdata=0x80123456 -> next cycle rf_we=1, rf_wdata=0xFFFFFF80. Same with sign=0 -> 0x00000080. Half, off=2, sign=1, rdata=0x8001_1234 -> 0xFFFF8001.
- Source select, back-to-back: mfc0 (sel=2, cp0=0xDEADBEEF, rd=12), then jal (sel=3, pc=0x00400010, rd=31) -> rf writes r12=0xDEADBEEF then r31=0x00400018 on consecutive cycles; retire_cnt=2.
- r0 and no-write: rd=0 with regwrite=1, and rd=5 with regwrite=0 -> rf_we stays 0, fwd_valid=0, retire_cnt still +1 each.
- Hold 3 cycles with entry rd=7, alu=0x55 -> in_ready=0, rf_we=0, fwd_valid=1 throughout; single rf_we pulse when hold drops; retire_cnt +1 only once.
- Flush during hold with in_valid=1 -> no write, in_ready=0 that cycle, v=0 after the edge, retire_cnt unchanged; the next input is accepted the following cycle.
- Counter wrap and reset: CNT_W=4, retire 17 instructions -> retire_cnt=1. Assert reset=0 while an entry is held -> v=0, retire_cnt=0, rf_we=0, and no write after release.
